// File: rtl/count_pkg.sv
// ============================================================================
// Module      : count_pkg
// Description : Shared types and defaults for the count wrap monitor slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package count_pkg;

    localparam int c_cnt_w   = 4;
    localparam int c_epoch_w = 8;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_UP   = 2'd2,
        ST_DOWN = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_JUMP = 2'd3
    } step_e;

endpackage

`default_nettype wire

// File: rtl/count_wrap_monitor_if.sv
// ============================================================================
// Module      : count_wrap_monitor_if
// Description : Counter sample/clear inputs and monitor result bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface count_wrap_monitor_if
    import count_pkg::*;
#(
    parameter int CNT_W   = c_cnt_w,
    parameter int EPOCH_W = c_epoch_w
);
    logic [CNT_W-1:0]         count_in;
    logic                     clr;
    logic                     ovf_pulse;
    logic                     unf_pulse;
    logic                     dir;
    logic                     dir_valid;
    logic [EPOCH_W-1:0]       epoch;
    logic [EPOCH_W+CNT_W-1:0] ext_count;
    logic                     stalled;
    logic                     jump_err;

    modport master (
        output count_in, clr,
        input  ovf_pulse, unf_pulse, dir, dir_valid, epoch, ext_count, stalled, jump_err
    );

    modport slave (
        input  count_in, clr,
        output ovf_pulse, unf_pulse, dir, dir_valid, epoch, ext_count, stalled, jump_err
    );

endinterface

`default_nettype wire

// File: rtl/count_wrap_monitor_sat_epoch_acc.sv
// ============================================================================
// Module      : sat_epoch_acc
// Description : Signed two's-complement +/-1 accumulator, saturating, sync clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_epoch_acc #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] acc
);
    localparam logic [W-1:0] c_max = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] c_min = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] r_acc;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_acc <= '0;
        end else if (inc && (r_acc != c_max)) begin
            r_acc <= r_acc + W'(1);
        end else if (dec && (r_acc != c_min)) begin
            r_acc <= r_acc - W'(1);
        end
    end

    assign acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/count_wrap_monitor.sv
// ============================================================================
// Module      : count_wrap_monitor
// Description : Classifies counter steps, flags wraps, stalls and jumps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_wrap_monitor
    import count_pkg::*;
#(
    parameter int CNT_W       = c_cnt_w,
    parameter int EPOCH_W     = c_epoch_w,
    parameter int STALL_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    count_wrap_monitor_if.slave mon
);
    localparam logic [1:0]       c_s_init    = ST_INIT;
    localparam logic [1:0]       c_s_idle    = ST_IDLE;
    localparam logic [1:0]       c_s_up      = ST_UP;
    localparam logic [1:0]       c_s_down    = ST_DOWN;
    localparam logic [CNT_W-1:0] c_cnt_max   = '1;
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [7:0]       c_stall_lim = 8'(STALL_LIMIT);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_prev;
    logic [CNT_W-1:0]   w_delta;
    step_e              w_step;
    logic               w_active;
    logic               w_ovf;
    logic               w_unf;
    logic [7:0]         r_stall_cnt;
    logic [7:0]         w_stall_nxt;
    logic               r_ovf;
    logic               r_unf;
    logic               r_dir;
    logic               r_dir_valid;
    logic               r_stalled;
    logic               r_jump_err;
    logic [EPOCH_W-1:0] w_epoch;

    assign w_delta = mon.count_in - r_prev;

    always_comb begin
        w_step = STEP_JUMP;
        if (w_delta == '0) begin
            w_step = STEP_HOLD;
        end else if (w_delta == c_cnt_one) begin
            w_step = STEP_UP;
        end else if (w_delta == c_cnt_max) begin
            w_step = STEP_DOWN;
        end
    end

    // The capture cycle after reset/clear compares against a stale prev, so it is ignored.
    assign w_active = rst && !mon.clr && (r_state != c_s_init);
    assign w_ovf    = w_active && (w_step == STEP_UP)   && (r_prev == c_cnt_max);
    assign w_unf    = w_active && (w_step == STEP_DOWN) && (r_prev == '0);

    assign w_stall_nxt = (w_step != STEP_HOLD)          ? 8'd0 :
                         (r_stall_cnt == c_stall_lim)   ? r_stall_cnt :
                                                          r_stall_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst || mon.clr) begin
            r_state     <= c_s_init;
            r_prev      <= rst ? mon.count_in : '0;
            r_stall_cnt <= 8'd0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_dir       <= 1'b0;
            r_dir_valid <= 1'b0;
            r_stalled   <= 1'b0;
            r_jump_err  <= 1'b0;
        end else begin
            r_prev <= mon.count_in;
            r_ovf  <= w_ovf;
            r_unf  <= w_unf;
            if (r_state == c_s_init) begin
                r_state <= c_s_idle;
            end else begin
                r_stall_cnt <= w_stall_nxt;
                r_stalled   <= (w_stall_nxt == c_stall_lim);
                if (w_step == STEP_JUMP) begin
                    r_jump_err <= 1'b1;
                end
                if (w_step == STEP_UP) begin
                    r_state     <= c_s_up;
                    r_dir       <= 1'b1;
                    r_dir_valid <= 1'b1;
                end else if (w_step == STEP_DOWN) begin
                    r_state     <= c_s_down;
                    r_dir       <= 1'b0;
                    r_dir_valid <= 1'b1;
                end
            end
        end
    end

    sat_epoch_acc #(
        .W (EPOCH_W)
    ) u_epoch (
        .clk (clk),
        .rst (rst),
        .clr (mon.clr),
        .inc (w_ovf),
        .dec (w_unf),
        .acc (w_epoch)
    );

    assign mon.ovf_pulse = r_ovf;
    assign mon.unf_pulse = r_unf;
    assign mon.dir       = r_dir;
    assign mon.dir_valid = r_dir_valid;
    assign mon.epoch     = w_epoch;
    assign mon.ext_count = {w_epoch, r_prev};
    assign mon.stalled   = r_stalled;
    assign mon.jump_err  = r_jump_err;

endmodule

`default_nettype wire

// File: tb/tb_count_wrap_monitor.sv
// ============================================================================
// Module      : tb_count_wrap_monitor
// Description : Self-checking bench: vector table, corner sequences, random run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_wrap_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [3:0] cin;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: arithmetic on integers, no notion of FSM encoding.
    int m_prev, m_epoch, m_stall;
    bit m_init, m_ovf, m_unf, m_dir, m_dv, m_jerr;

    count_wrap_monitor_if #(.CNT_W(4), .EPOCH_W(8)) bus ();

    assign bus.count_in = cin;
    assign bus.clr      = clr;

    count_wrap_monitor #(
        .CNT_W       (4),
        .EPOCH_W     (8),
        .STALL_LIMIT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mon (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       c;
        logic [3:0] v;
        logic       ovf;
        logic       unf;
        logic       dir;
        logic       dv;
        logic       jerr;
        logic       st;
        logic [7:0] ep;
        logic [11:0] ext;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit c, input int v);
        int d;
        m_ovf = 0;
        m_unf = 0;
        if (!r || c) begin
            m_init  = 1;
            m_prev  = r ? v : 0;
            m_epoch = 0;
            m_stall = 0;
            m_dir   = 0;
            m_dv    = 0;
            m_jerr  = 0;
        end else if (m_init) begin
            m_init = 0;
            m_prev = v;
        end else begin
            d = (v - m_prev + 16) % 16;
            m_ovf = (d == 1)  && (m_prev == 15);
            m_unf = (d == 15) && (m_prev == 0);
            if (d == 1)  begin m_dir = 1; m_dv = 1; end
            if (d == 15) begin m_dir = 0; m_dv = 1; end
            if (d != 0 && d != 1 && d != 15) m_jerr = 1;
            m_stall = (d == 0) ? ((m_stall < 8) ? m_stall + 1 : 8) : 0;
            if (m_ovf && m_epoch < 127)  m_epoch++;
            if (m_unf && m_epoch > -128) m_epoch--;
            m_prev = v;
        end
    endtask

    task automatic check_model();
        chk("model_ovf",     int'(bus.ovf_pulse), int'(m_ovf));
        chk("model_unf",     int'(bus.unf_pulse), int'(m_unf));
        chk("model_dir",     int'(bus.dir),       int'(m_dir));
        chk("model_dvalid",  int'(bus.dir_valid), int'(m_dv));
        chk("model_epoch",   int'(bus.epoch),     m_epoch & 255);
        chk("model_ext",     int'(bus.ext_count), ((m_epoch & 255) << 4) | m_prev);
        chk("model_stalled", int'(bus.stalled),   int'(m_stall == 8));
        chk("model_jerr",    int'(bus.jump_err),  int'(m_jerr));
    endtask

    task automatic tick(input logic r, input logic c, input logic [3:0] v);
        rst = r;
        clr = c;
        cin = v;
        @(posedge clk);
        model_step(r, c, int'(v));
        #1;
        check_model();
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, int'({bus.ovf_pulse, bus.unf_pulse, bus.dir, bus.dir_valid,
                        bus.epoch, bus.ext_count, bus.stalled, bus.jump_err}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ovf, n_unf, cur, p;
        rst = 1'b0;
        clr = 1'b0;
        cin = 4'd0;
        #2;

        // r c  v     ovf unf dir dv jerr st  epoch  ext
        tbl[0]  = '{1'b0, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000};
        tbl[1]  = '{1'b1, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'h003};
        tbl[2]  = '{1'b1, 1'b0, 4'd4,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 12'h004};
        tbl[3]  = '{1'b1, 1'b0, 4'd4,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 12'h004};
        tbl[4]  = '{1'b1, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 12'h003};
        tbl[5]  = '{1'b1, 1'b0, 4'd2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 12'h002};
        tbl[6]  = '{1'b1, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 12'h001};
        tbl[7]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000};
        tbl[8]  = '{1'b1, 1'b0, 4'd15, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 12'hFFF};
        tbl[9]  = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000};
        tbl[10] = '{1'b1, 1'b0, 4'd5,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 12'h005};
        tbl[11] = '{1'b1, 1'b0, 4'd6,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 12'h006};
        tbl[12] = '{1'b1, 1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'h009};
        tbl[13] = '{1'b1, 1'b0, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'h008};
        tbl[14] = '{1'b1, 1'b0, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 12'h007};

        for (int i = 0; i < 15; i++) begin
            tick(tbl[i].r, tbl[i].c, tbl[i].v);
            chk($sformatf("tbl%0d_ovf", i),   int'(bus.ovf_pulse), int'(tbl[i].ovf));
            chk($sformatf("tbl%0d_unf", i),   int'(bus.unf_pulse), int'(tbl[i].unf));
            chk($sformatf("tbl%0d_dir", i),   int'(bus.dir),       int'(tbl[i].dir));
            chk($sformatf("tbl%0d_dv", i),    int'(bus.dir_valid), int'(tbl[i].dv));
            chk($sformatf("tbl%0d_jerr", i),  int'(bus.jump_err),  int'(tbl[i].jerr));
            chk($sformatf("tbl%0d_stall", i), int'(bus.stalled),   int'(tbl[i].st));
            chk($sformatf("tbl%0d_epoch", i), int'(bus.epoch),     int'(tbl[i].ep));
            chk($sformatf("tbl%0d_ext", i),   int'(bus.ext_count), int'(tbl[i].ext));
        end

        // Held at zero: stalled from the 8th compare (capture edge is not a compare).
        tick(1'b0, 1'b0, 4'd0);
        for (int k = 1; k <= 11; k++) begin
            tick(1'b1, 1'b0, 4'd0);
            if (k >= 2) chk($sformatf("hold_stalled_cmp%0d", k - 1), int'(bus.stalled), int'((k - 1) >= 8));
            chk("hold_no_pulse", int'(bus.ovf_pulse | bus.unf_pulse), 0);
        end
        chk("hold_dvalid", int'(bus.dir_valid), 0);

        // Single overflow 15 -> 0.
        tick(1'b0, 1'b0, 4'd0);
        tick(1'b1, 1'b0, 4'd0);
        n_ovf = 0;
        for (int v = 1; v <= 16; v++) begin
            tick(1'b1, 1'b0, 4'(v));
            n_ovf += int'(bus.ovf_pulse);
        end
        chk("up_ovf_last",  int'(bus.ovf_pulse), 1);
        chk("up_ovf_count", n_ovf, 1);
        chk("up_epoch",     int'(bus.epoch), 1);
        chk("up_ext",       int'(bus.ext_count), 'h010);
        chk("up_dir",       int'(bus.dir), 1);

        // Two underflows going down twice around the ring.
        tick(1'b0, 1'b0, 4'd0);
        tick(1'b1, 1'b0, 4'd0);
        n_unf = 0;
        for (int i = 1; i <= 32; i++) begin
            tick(1'b1, 1'b0, 4'((16 - (i % 16)) % 16));
            n_unf += int'(bus.unf_pulse);
        end
        chk("down_unf_count", n_unf, 2);
        chk("down_epoch",     int'(bus.epoch), 'hFE);
        chk("down_dir",       int'(bus.dir), 0);

        // Jump 5 -> 9 is sticky and leaves epoch/direction alone; clr wipes it.
        tick(1'b0, 1'b0, 4'd0);
        tick(1'b1, 1'b0, 4'd4);
        tick(1'b1, 1'b0, 4'd5);
        tick(1'b1, 1'b0, 4'd9);
        chk("jump_err_set", int'(bus.jump_err), 1);
        chk("jump_epoch",   int'(bus.epoch), 0);
        chk("jump_dir",     int'(bus.dir), 1);
        tick(1'b1, 1'b0, 4'd10);
        chk("jump_err_sticky", int'(bus.jump_err), 1);
        tick(1'b1, 1'b1, 4'd10);
        chk("clr_jump_err", int'(bus.jump_err), 0);
        chk("clr_epoch",    int'(bus.epoch), 0);
        chk("clr_ext",      int'(bus.ext_count), 'h00A);

        // 129 overflows: epoch saturates at 127, pulses keep firing.
        tick(1'b0, 1'b0, 4'd0);
        tick(1'b1, 1'b0, 4'd0);
        n_ovf = 0;
        for (int i = 1; i <= 129 * 16; i++) begin
            tick(1'b1, 1'b0, 4'(i % 16));
            n_ovf += int'(bus.ovf_pulse);
            if (i == 128 * 16) begin
                chk("sat_128th_pulse", int'(bus.ovf_pulse), 1);
                chk("sat_128th_epoch", int'(bus.epoch), 127);
            end
        end
        chk("sat_pulse_count", n_ovf, 129);
        chk("sat_epoch",       int'(bus.epoch), 127);
        chk("sat_last_pulse",  int'(bus.ovf_pulse), 1);

        // Reset held mid-count: no classification across it.
        tick(1'b0, 1'b0, 4'd0);
        tick(1'b1, 1'b0, 4'd0);
        for (int v = 1; v <= 7; v++) tick(1'b1, 1'b0, 4'(v));
        tick(1'b0, 1'b0, 4'd7);
        chk_all_zero("midrst_cycle1");
        tick(1'b0, 1'b0, 4'd9);
        chk_all_zero("midrst_cycle2");
        tick(1'b1, 1'b0, 4'd12);
        chk("midrst_release_jerr", int'(bus.jump_err), 0);
        chk("midrst_release_dv",   int'(bus.dir_valid), 0);
        chk("midrst_release_ext",  int'(bus.ext_count), 'h00C);
        tick(1'b1, 1'b0, 4'd13);
        chk("midrst_first_cls_dv",   int'(bus.dir_valid), 1);
        chk("midrst_first_cls_dir",  int'(bus.dir), 1);
        chk("midrst_first_cls_jerr", int'(bus.jump_err), 0);

        // Random walk checked every cycle against the reference state.
        tick(1'b0, 1'b0, 4'd0);
        cur = 0;
        for (int i = 0; i < 800; i++) begin
            p = int'($urandom_range(0, 9));
            if (p <= 3)      cur = cur;
            else if (p <= 6) cur = (cur + 1) % 16;
            else if (p <= 8) cur = (cur + 15) % 16;
            else             cur = int'($urandom_range(0, 15));
            tick(logic'($urandom_range(0, 49) != 0), logic'($urandom_range(0, 59) == 0), 4'(cur));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
